fetch_stage: RTL

Instruction-fetch stage of `processor_pipelined`, feeding the IF/ID register that the decode stage consumes. It owns the program counter, issues requests to a one-cycle-latency instruction memory, and absorbs decode stalls with a one-entry skid buffer. It applies taken-branch redirects from decode and stops fetching on the halt instruction, so the `pipelinedstim` run ends in a known state.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_skid_buffer.sv | 57 +++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the pipelined CPU front end.
package cpu_pkg;

   // AArch64 NOP, shown in IF/ID while it holds no real instruction.
   localparam logic [31:0] NOP_INSTR  = 32'hD503201F;
   // "B ." self-loop; ends the program and stops fetching.
   localparam logic [31:0] HALT_INSTR = 32'h14000000;

   typedef enum logic [0:0] {
      FETCH,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, decode-control and IF/ID signals.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
) ();

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               ifid_valid;
   logic [ADDR_W-1:0]  ifid_pc;
   logic [INSTR_W-1:0] ifid_instr;
   logic               halted;

   // Fetch stage side.
   modport master (
      output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, halted,
      input  imem_rdata, stall, redirect, redirect_pc
   );

   // Memory / decode side.
   modport slave (
      input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, halted,
      output imem_rdata, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding slot; contents readable in the same cycle.
module fetch_skid_buffer
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               clear,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   output logic               full,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instr
);

   logic               full_q, full_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   // Next entry state: clear wins over push, push wins over pop.
   always_comb begin
      full_d  = full_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (push) begin
         full_d  = 1'b1;
         pc_d    = push_pc;
         instr_d = push_instr;
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   // Entry register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q  <= 1'b0;
         pc_q    <= '0;
         instr_q <= INSTR_W'(NOP_INSTR);
      end else begin
         full_q  <= full_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign full  = full_q;
   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-cycle imem issue, skid-buffered stalls, redirects, halt.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic            clk,
   input logic            reset,
   fetch_stage_if.master  bus
);

   localparam logic [INSTR_W-1:0] NopW       = INSTR_W'(NOP_INSTR);
   localparam logic [INSTR_W-1:0] HaltW      = INSTR_W'(HALT_INSTR);
   localparam logic [ADDR_W-1:0]  PcStep     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0]  AlignMask  = ~ADDR_W'(3);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               inflight_v_q, inflight_v_d;
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic               halted_q;

   logic               in_fetch, redirect_act, issue, ifid_write;
   logic               skid_push, skid_pop, skid_clear, skid_full;
   logic [ADDR_W-1:0]  skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   fetch_skid_buffer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk        (clk),
      .reset      (reset),
      .push       (skid_push),
      .pop        (skid_pop),
      .clear      (skid_clear),
      .push_pc    (inflight_pc_q),
      .push_instr (bus.imem_rdata),
      .full       (skid_full),
      .pc         (skid_pc),
      .instr      (skid_instr)
   );

   assign in_fetch     = (state_q == FETCH);
   assign redirect_act = in_fetch & bus.redirect & ~bus.stall;
   // Never issue when the reply would have nowhere to go: skid occupied, or a
   // stalled reply is about to take the skid this cycle.
   assign issue        = in_fetch & ~skid_full & ~(bus.stall & inflight_v_q) & ~bus.redirect;

   // Next-state: PC, in-flight tracking, response routing into IF/ID or skid, halt detect.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_v_d  = issue;
      inflight_pc_d = inflight_pc_q;
      ifid_valid_d  = ifid_valid_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_write    = 1'b0;
      skid_push     = 1'b0;
      skid_pop      = 1'b0;
      skid_clear    = 1'b0;

      if (issue) begin
         pc_d          = pc_q + PcStep;
         inflight_pc_d = pc_q;
      end

      if (redirect_act) begin
         // Drop everything fetched down the wrong path.
         pc_d         = bus.redirect_pc & AlignMask;
         inflight_v_d = 1'b0;
         skid_clear   = 1'b1;
         ifid_valid_d = 1'b0;
      end else if (!in_fetch) begin
         // Halted: late replies are ignored, IF/ID drains to bubbles.
         if (!bus.stall) begin
            ifid_valid_d = 1'b0;
         end
      end else if (bus.stall) begin
         if (inflight_v_q) begin
            skid_push = 1'b1;
         end
      end else if (skid_full) begin
         skid_pop     = 1'b1;
         ifid_write   = 1'b1;
         ifid_valid_d = 1'b1;
         ifid_pc_d    = skid_pc;
         ifid_instr_d = skid_instr;
      end else if (inflight_v_q) begin
         ifid_write   = 1'b1;
         ifid_valid_d = 1'b1;
         ifid_pc_d    = inflight_pc_q;
         ifid_instr_d = bus.imem_rdata;
      end else begin
         ifid_valid_d = 1'b0;
      end

      if (ifid_write && (ifid_instr_d == HaltW)) begin
         state_d = HALT;
      end
   end

   // State, PC, in-flight and IF/ID registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         inflight_v_q  <= 1'b0;
         inflight_pc_q <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_pc_q     <= '0;
         ifid_instr_q  <= NopW;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_v_q  <= inflight_v_d;
         inflight_pc_q <= inflight_pc_d;
         ifid_valid_q  <= ifid_valid_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_instr_q  <= ifid_instr_d;
         halted_q      <= (state_q == HALT);
      end
   end

   assign bus.imem_req   = issue;
   assign bus.imem_addr  = pc_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.ifid_pc    = ifid_pc_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.halted     = halted_q;

`ifndef SYNTHESIS
   // Decode must not resolve a branch while it is itself stalled.
   a_no_redirect_in_stall : assert property (
      @(posedge clk) disable iff (!reset) !(bus.redirect && bus.stall)
   ) else $error("fetch_stage: redirect asserted together with stall");
`endif

endmodule
